// File: rtl/sqr_pkg.sv
// Shared types and default widths for the sequential squarer.
package sqr_pkg;

    localparam int XW = 10;
    localparam int SW = 2 * XW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sqr_fsm.sv
// Controller for sqr_seq: sequences load, per-cycle accumulation and result capture.
module sqr_fsm
    import sqr_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic cnt_zero,
    input  logic sat,
    output logic ld,
    output logic acc_en,
    output logic sq_ld,
    output logic busy,
    output logic done
);

    state_t state, state_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        acc_en   = 1'b0;
        sq_ld    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ld       = 1'b1;
                    state_nx = ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                // Either the count ran out or the running sum would pass 16 bits.
                if (cnt_zero || sat) begin
                    sq_ld    = 1'b1;
                    state_nx = DONE;
                end else begin
                    acc_en = 1'b1;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/sqr_seq.sv
// Sequential squarer: x*x as the sum of the first x odd numbers, one term per cycle.
// Build option SQR_SAT16_EN: saturate to 16'hFFFF with early exit.
module sqr_seq #(
    parameter int XW = sqr_pkg::XW,
    parameter int SW = 2 * XW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] sq
);

    logic [SW-1:0] acc;
    logic [XW:0]   odd;
    logic [XW-1:0] cnt;
    logic          ld, acc_en, sq_ld, cnt_zero, sat;

    assign cnt_zero = (cnt == '0);

`ifdef SQR_SAT16_EN
    localparam logic [SW:0] SAT_MAX = (SW+1)'(16'hFFFF);

    function automatic logic over_16(input logic [SW-1:0] a, input logic [XW:0] o);
        return ({1'b0, a} + (SW+1)'(o)) > SAT_MAX;
    endfunction

    function automatic logic [SW-1:0] sat16(input logic s, input logic [SW-1:0] a);
        return s ? SW'(16'hFFFF) : a;
    endfunction

    assign sat = !cnt_zero && over_16(acc, odd);
`else
    assign sat = 1'b0;
`endif

    sqr_fsm u_fsm (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cnt_zero (cnt_zero),
        .sat      (sat),
        .ld       (ld),
        .acc_en   (acc_en),
        .sq_ld    (sq_ld),
        .busy     (busy),
        .done     (done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            odd <= (XW+1)'(1);
            cnt <= '0;
            sq  <= '0;
        end else begin
            if (ld) begin
                cnt <= x;
                acc <= '0;
                odd <= (XW+1)'(1);
            end else if (acc_en) begin
                acc <= acc + SW'(odd);
                odd <= odd + (XW+1)'(2);
                cnt <= cnt - XW'(1);
            end
            if (sq_ld) begin
`ifdef SQR_SAT16_EN
                sq <= sat16(sat, acc);
`else
                sq <= acc;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sqr_seq.sv
// Directed self-checking bench for sqr_seq (latency, result, busy/done, abort, start-ignore).
module tb_sqr_seq;

    localparam int XW = 10;
    localparam int SW = 20;

    logic          clk;
    logic          reset;
    logic          start;
    logic [XW-1:0] x;
    logic          busy;
    logic          done;
    logic [SW-1:0] sq;

    int total;
    int bad;

    sqr_seq #(.XW(XW), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .busy  (busy),
        .done  (done),
        .sq    (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start for one edge (edge 0); returns 1 ns after that edge.
    task automatic start_op(input logic [XW-1:0] v);
        start = 1'b1;
        x     = v;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Number of edges after edge 0 until done is seen; -1 if it never arrives.
    task automatic wait_done(output int edges);
        edges = -1;
        for (int k = 1; k <= 1100; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        x     = '0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (sq !== '0) begin bad++; $display("FAIL reset_sq got=%0d exp=0", sq); end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_zero();
        start_op(10'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy_e0 got=%b exp=1", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_e0 got=%b exp=0", done); end
        @(posedge clk); #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done_e1 got=%b exp=1", done); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy_e1 got=%b exp=1", busy); end
        total++; if (sq !== 20'd0) begin bad++; $display("FAIL zero_sq got=%0d exp=0", sq); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_e2 got=%b exp=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_e2 got=%b exp=0", busy); end
    endtask

    task automatic test_three();
        int e;
        int changes;
        start_op(10'd3);
        wait_done(e);
        total++; if (e !== 4) begin bad++; $display("FAIL three_latency got=%0d exp=4", e); end
        total++; if (sq !== 20'd9) begin bad++; $display("FAIL three_sq got=%0d exp=9", sq); end
        changes = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (sq !== 20'd9) changes++;
        end
        total++; if (changes !== 0) begin bad++; $display("FAIL three_sq_hold got=%0d changes exp=0", changes); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL three_done_after got=%b exp=0", done); end
    endtask

`ifndef SQR_SAT16_EN
    task automatic test_max();
        int e;
        start_op(10'd1023);
        wait_done(e);
        total++; if (e !== 1024) begin bad++; $display("FAIL max_latency got=%0d exp=1024", e); end
        total++; if (sq !== 20'd1046529) begin bad++; $display("FAIL max_sq got=%0d exp=1046529", sq); end
        @(posedge clk); #1;
    endtask
`else
    task automatic test_sat();
        int e;
        start_op(10'd300);
        wait_done(e);
        total++; if (e !== 256) begin bad++; $display("FAIL sat300_latency got=%0d exp=256", e); end
        total++; if (sq !== 20'h0FFFF) begin bad++; $display("FAIL sat300_sq got=%0d exp=65535", sq); end
        @(posedge clk); #1;
        start_op(10'd255);
        wait_done(e);
        total++; if (e !== 256) begin bad++; $display("FAIL sat255_latency got=%0d exp=256", e); end
        total++; if (sq !== 20'd65025) begin bad++; $display("FAIL sat255_sq got=%0d exp=65025", sq); end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_ignore_start();
        int e;
        int extra;
        start = 1'b1;
        x     = 10'd5;
        @(posedge clk); #1;
        x = 10'd7;
        wait_done(e);
        start = 1'b0;
        total++; if (e !== 6) begin bad++; $display("FAIL ign_latency got=%0d exp=6", e); end
        total++; if (sq !== 20'd25) begin bad++; $display("FAIL ign_sq got=%0d exp=25", sq); end
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL ign_extra_done got=%0d exp=0", extra); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy_idle got=%b exp=0", busy); end
        start_op(10'd7);
        wait_done(e);
        total++; if (e !== 8) begin bad++; $display("FAIL seven_latency got=%0d exp=8", e); end
        total++; if (sq !== 20'd49) begin bad++; $display("FAIL seven_sq got=%0d exp=49", sq); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int e;
        int seen;
        start_op(10'd10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (sq !== 20'd0) begin bad++; $display("FAIL abort_sq got=%0d exp=0", sq); end
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        reset = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_done_pulses got=%0d exp=0", seen); end
        total++; if (sq !== 20'd0) begin bad++; $display("FAIL abort_sq_after got=%0d exp=0", sq); end
        // Release and start together: the very next edge must accept.
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        start_op(10'd2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_start_busy got=%b exp=1", busy); end
        wait_done(e);
        total++; if (e !== 3) begin bad++; $display("FAIL two_latency got=%0d exp=3", e); end
        total++; if (sq !== 20'd4) begin bad++; $display("FAIL two_sq got=%0d exp=4", sq); end
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero();
        test_three();
`ifndef SQR_SAT16_EN
        test_max();
`else
        test_sat();
`endif
        test_ignore_start();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
